// File: rtl/uart_tx_slave.sv
// rtl/uart_tx_slave.sv - bus-mapped 8N1 UART transmitter with a byte TX FIFO
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always lost.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

module uart_tx_slave #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        uart_int
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [15:0]   baud_q, baud_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          uart_int_q, uart_int_d;

  logic          bus_wr, bus_rd;
  logic [1:0]    reg_idx;
  logic          push, w1c, pop, done_set, bit_end;
  logic [15:0]   period_m1;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_bits;

  assign bus_wr  = ce & we;
  assign bus_rd  = ce & ~we;
  assign reg_idx = addr[3:2];
  assign push    = bus_wr & (reg_idx == 2'd0) & sel[0];
  assign w1c     = bus_wr & (reg_idx == 2'd1) & sel[0];

  assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:2], data_i[31:16]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (data_i[7:0]),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A divisor of 0 behaves as 1; the value is sampled only when a bit starts.
  assign period_m1 = (baud_q == 16'd0) ? 16'd0 : baud_q - 16'd1;
  assign bit_end   = (cnt_q == 16'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0] && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          cnt_d   = period_m1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          cnt_d   = period_m1;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = period_m1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so frames go out back-to-back.
          if (ctrl_q[0] && !fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            cnt_d   = period_m1;
            state_d = ST_START;
          end else begin
            state_d  = ST_IDLE;
            done_set = fifo_empty;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line is driven one cycle behind the FSM state.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    baud_d     = baud_q;
    ovf_d      = ovf_q;
    done_d     = done_q;
    uart_int_d = done_q & ctrl_q[1];
    if (bus_wr && reg_idx == 2'd2 && sel[0]) ctrl_d = data_i[1:0];
    if (bus_wr && reg_idx == 2'd3 && sel[0]) baud_d[7:0] = data_i[7:0];
    if (bus_wr && reg_idx == 2'd3 && sel[1]) baud_d[15:8] = data_i[15:8];
    if (push && fifo_full)      ovf_d = 1'b1;
    else if (w1c && data_i[3])  ovf_d = 1'b0;
    if (done_set)               done_d = 1'b1;
    else if (w1c && data_i[4])  done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
      ctrl_q     <= 2'd0;
      baud_q     <= DIV_RESET;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      uart_int_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      uart_int_q <= uart_int_d;
    end
  end

  assign status = {16'h0, 8'(fifo_count), 3'b000, done_q, ovf_q,
                   (state_q != ST_IDLE), fifo_empty, fifo_full};

  always_comb begin
    data_o = 32'h0;
    if (bus_rd) begin
      case (reg_idx)
        2'd1:    data_o = status;
        2'd2:    data_o = {30'h0, ctrl_q};
        2'd3:    data_o = {16'h0, baud_q};
        default: data_o = 32'h0;
      endcase
    end
  end

  assign txd      = txd_q;
  assign uart_int = uart_int_q;
endmodule

// File: tb/tb_uart_tx_slave.sv
// tb/tb_uart_tx_slave.sv - directed and randomized checks of uart_tx_slave
module tb_uart_tx_slave;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        txd;
  logic        uart_int;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_q[$];

  uart_tx_slave #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .txd(txd), .uart_int(uart_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    ce = 1'b1; we = 1'b1; addr = {28'h0, r, 2'b00}; data_i = d; sel = s;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = {28'h0, r, 2'b00}; sel = 4'hf;
    #1;
    d = data_o;
    ce = 1'b0; sel = 4'h0;
  endtask

  function automatic logic [31:0] st(input int cnt, input bit busy, input bit ovf, input bit done);
    return {16'h0, 8'(cnt), 3'b000, done, ovf, busy, (cnt == 0), (cnt == DEPTH)};
  endfunction

  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (txd !== 1'b0 && n < limit) begin
      step();
      n++;
    end
  endtask

  // Expected line: start bit for p0 cycles, then 8 data bits LSB first and a stop bit of p cycles each.
  task automatic check_frame(input string tag, input logic [7:0] b, input int p0, input int p, input int skip);
    int total;
    int errs;
    logic [7:0] rx;
    logic e;
    total = p0 + 9 * p;
    errs = 0;
    rx = 8'h0;
    for (int i = skip; i < total; i++) begin
      if (i < p0) e = 1'b0;
      else if ((i - p0) / p < 8) e = b[(i - p0) / p];
      else e = 1'b1;
      if (txd !== e) errs++;
      if (i >= p0 && (i - p0) / p < 8 && (i - p0) % p == p / 2) rx[(i - p0) / p] = txd;
      step();
    end
    chk({tag, "_wave"}, 32'(errs), 32'd0);
    chk({tag, "_data"}, {24'h0, rx}, {24'h0, b});
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b, x, y;
    int          n, nb, p;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("txd_in_reset", 32'(txd), 32'd1);
    rst = 1'b1;
    step();
    bus_read(2'd1, r); chk("rst_status", r, 32'h2);
    bus_read(2'd2, r); chk("rst_ctrl", r, 32'h0);
    bus_read(2'd3, r); chk("rst_baud", r, 32'd434);
    bus_read(2'd0, r); chk("rst_txdata", r, 32'h0);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_int", 32'(uart_int), 32'd0);
    chk("deselected_bus", data_o, 32'h0);

    // single frame A5 at P=4
    bus_write(2'd3, 32'd4, 4'h3);
    bus_write(2'd2, 32'd1, 4'h1);
    bus_write(2'd0, 32'hA5, 4'h1);
    wait_start(10, n); chk("a5_latency", 32'(n), 32'd2);
    check_frame("a5", 8'hA5, 4, 4, 0);
    bus_read(2'd1, r); chk("a5_status", r, st(0, 0, 0, 1));

    // overflow with tx disabled, then back-to-back drain
    bus_write(2'd1, 32'h10, 4'h1);
    bus_write(2'd2, 32'd0, 4'h1);
    model_q.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      bus_write(2'd0, {24'h0, b}, 4'h1);
      if (model_q.size() < DEPTH) model_q.push_back(b);
    end
    bus_read(2'd1, r); chk("ovf_status", r, st(8, 0, 1, 0));
    bus_write(2'd2, 32'd1, 4'h1);
    wait_start(10, n); chk("b2b_latency", 32'(n), 32'd2);
    for (int i = 0; i < 8; i++) check_frame($sformatf("b2b%0d", i), model_q.pop_front(), 4, 4, 0);
    bus_read(2'd1, r); chk("b2b_status", r, st(0, 0, 1, 1));
    bus_write(2'd1, 32'h8, 4'h1);
    bus_read(2'd1, r); chk("ovf_w1c", r, st(0, 0, 0, 1));

    // interrupt timing
    bus_write(2'd1, 32'h10, 4'h1);
    bus_write(2'd3, 32'd1, 4'h3);
    bus_write(2'd2, 32'd3, 4'h1);
    bus_write(2'd0, 32'h00, 4'h1);
    wait_start(10, n); chk("int_latency", 32'(n), 32'd2);
    n = 0;
    bus_read(2'd1, r);
    while (r[4] !== 1'b1 && n < 40) begin
      step(); n++;
      bus_read(2'd1, r);
    end
    chk("int_done_seen", 32'(r[4]), 32'd1);
    chk("int_before", 32'(uart_int), 32'd0);
    step();
    chk("int_after", 32'(uart_int), 32'd1);
    bus_write(2'd1, 32'h10, 4'h1);
    bus_read(2'd1, r); chk("done_w1c", 32'(r[4]), 32'd0);
    chk("int_lag", 32'(uart_int), 32'd1);
    step();
    chk("int_cleared", 32'(uart_int), 32'd0);
    b = 8'($urandom);
    bus_write(2'd0, {24'h0, b}, 4'h1);
    n = 0;
    while (uart_int !== 1'b1 && n < 40) begin step(); n++; end
    chk("int_again", 32'(uart_int), 32'd1);
    bus_write(2'd2, 32'd1, 4'h1);
    step();
    chk("int_masked", 32'(uart_int), 32'd0);
    bus_read(2'd1, r); chk("masked_done", 32'(r[4]), 32'd1);

    // push coinciding with the idle pop
    bus_write(2'd1, 32'h10, 4'h1);
    bus_write(2'd2, 32'd0, 4'h1);
    bus_write(2'd3, 32'd2, 4'h3);
    x = 8'($urandom); y = 8'($urandom);
    bus_write(2'd0, {24'h0, x}, 4'h1);
    bus_write(2'd2, 32'd1, 4'h1);
    bus_write(2'd0, {24'h0, y}, 4'h1);
    bus_read(2'd1, r); chk("pushpop_status", r, st(1, 1, 0, 0));
    wait_start(10, n); chk("pushpop_latency", 32'(n), 32'd1);
    check_frame("pp_x", x, 2, 2, 0);
    check_frame("pp_y", y, 2, 2, 0);
    bus_read(2'd1, r); chk("pushpop_end", r, st(0, 0, 0, 1));

    // randomized bursts; pointers wrap repeatedly
    for (int round = 0; round < 3; round++) begin
      nb = $urandom_range(8, 3);
      p = $urandom_range(3, 1);
      bus_write(2'd1, 32'h10, 4'h1);
      bus_write(2'd2, 32'd0, 4'h1);
      bus_write(2'd3, 32'(p), 4'h3);
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        model_q.push_back(b);
        bus_write(2'd0, {24'h0, b}, 4'h1);
      end
      bus_read(2'd1, r); chk($sformatf("rnd%0d_count", round), r, st(nb, 0, 0, 0));
      bus_write(2'd2, 32'd1, 4'h1);
      wait_start(10, n); chk($sformatf("rnd%0d_latency", round), 32'(n), 32'd2);
      while (model_q.size() > 0) check_frame($sformatf("rnd%0d", round), model_q.pop_front(), p, p, 0);
      bus_read(2'd1, r); chk($sformatf("rnd%0d_end", round), r, st(0, 0, 0, 1));
    end

    // asynchronous reset during DATA
    bus_write(2'd1, 32'h10, 4'h1);
    bus_write(2'd3, 32'd4, 4'h3);
    bus_write(2'd2, 32'd1, 4'h1);
    bus_write(2'd0, 32'h00, 4'h1);
    bus_write(2'd0, 32'h3C, 4'h1);
    wait_start(10, n);
    repeat (10) step();
    chk("pre_reset_txd", 32'(txd), 32'd0);
    #2 rst = 1'b0;
    #1 chk("reset_txd", 32'(txd), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();
    bus_read(2'd1, r); chk("post_reset_status", r, 32'h2);
    bus_read(2'd2, r); chk("post_reset_ctrl", r, 32'h0);
    bus_read(2'd3, r); chk("post_reset_baud", r, 32'd434);

    // tx_en cleared mid-frame
    bus_write(2'd3, 32'd2, 4'h3);
    bus_write(2'd2, 32'd1, 4'h1);
    x = 8'($urandom); y = 8'($urandom);
    bus_write(2'd0, {24'h0, x}, 4'h1);
    bus_write(2'd0, {24'h0, y}, 4'h1);
    wait_start(10, n); chk("txen_latency", 32'(n), 32'd1);
    bus_write(2'd2, 32'd0, 4'h1);
    check_frame("txen_x", x, 2, 2, 1);
    bus_read(2'd1, r); chk("txen_idle", r, st(1, 0, 0, 0));
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (txd !== 1'b1) n++;
      step();
    end
    chk("txen_quiet", 32'(n), 32'd0);

    // divisor change mid start bit applies from the next bit
    bus_write(2'd3, 32'd4, 4'h3);
    bus_write(2'd2, 32'd1, 4'h1);
    wait_start(10, n); chk("baud_latency", 32'(n), 32'd2);
    bus_write(2'd3, 32'd2, 4'h3);
    check_frame("baud_change", y, 4, 2, 1);
    bus_read(2'd1, r); chk("baud_end", r, st(0, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
